// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types and constants for the Ascon-128 round sequencer
package ascon_pack;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_WAIT_PT,
    S_PT,
    S_FINAL,
    S_END
  } type_seq_state;

  localparam int ROUNDS_A_DEF = 12;
  localparam int ROUNDS_B_DEF = 6;
  localparam logic [3:0] LAST_ROUND = 4'd11;

  // A p^N permutation runs the tail of the 12-round schedule.
  function automatic logic [3:0] first_round(int rounds);
    return 4'(12 - rounds);
  endfunction

endpackage

// File: rtl/ascon_sequencer_if.sv
// rtl/ascon_sequencer_if.sv - block handshake and datapath control bundle of the sequencer
interface ascon_sequencer_if;
  logic       start_i;
  logic       block_valid_i;
  logic       block_is_ad_i;
  logic       block_last_i;
  logic       block_ready_o;
  logic [3:0] round_o;
  logic       data_sel_o;
  logic       en_reg_state_o;
  logic       en_xor_data_o;
  logic       en_xor_key_begin_o;
  logic       en_xor_key_end_o;
  logic       en_xor_lsb_o;
  logic       en_cipher_o;
  logic       en_tag_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, block_valid_i, block_is_ad_i, block_last_i,
    input  block_ready_o, round_o, data_sel_o, en_reg_state_o, en_xor_data_o,
           en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o, en_cipher_o,
           en_tag_o, busy_o, done_o
  );

  modport slave (
    input  start_i, block_valid_i, block_is_ad_i, block_last_i,
    output block_ready_o, round_o, data_sel_o, en_reg_state_o, en_xor_data_o,
           en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o, en_cipher_o,
           en_tag_o, busy_o, done_o
  );
endinterface

// File: rtl/round_counter.sv
// rtl/round_counter.sv - loadable round index counter that saturates at the last round
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] count,
  output logic       last
);

  assign last = (count == LAST_ROUND);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !last) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_sequencer.sv
// rtl/ascon_sequencer.sv - control FSM sequencing one Ascon-128 encryption over the round datapath
module ascon_sequencer
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEF,
  parameter int ROUNDS_B = ROUNDS_B_DEF
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  ascon_sequencer_if.slave bus
);

  localparam logic [3:0] FIRST_A = first_round(ROUNDS_A);
  localparam logic [3:0] FIRST_B = first_round(ROUNDS_B);

  type_seq_state state_q, state_d;
  logic          ad_last_q;
  logic          lsb_done_q;
  logic          cnt_load;
  logic [3:0]    cnt_val;
  logic [3:0]    cnt;
  logic          cnt_last;
  logic          in_round;
  logic          is_first;
  logic          pt_phase;

  round_counter u_round_counter (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .load    (cnt_load),
    .load_val(cnt_val),
    .en      (in_round),
    .count   (cnt),
    .last    (cnt_last)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q    <= S_IDLE;
      ad_last_q  <= 1'b0;
      lsb_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT_AD && bus.block_valid_i && bus.block_is_ad_i) begin
        ad_last_q <= bus.block_last_i;
      end
      if (state_q == S_IDLE) begin
        lsb_done_q <= 1'b0;
      end else if (bus.en_xor_lsb_o) begin
        lsb_done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = FIRST_A;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d  = S_INIT;
          cnt_load = 1'b1;
        end
      end
      S_INIT: if (cnt_last) state_d = S_WAIT_AD;
      S_WAIT_AD, S_WAIT_PT: begin
        // Without AD the first block lands here and is handled as a PT block.
        if (bus.block_valid_i) begin
          cnt_load = 1'b1;
          if (state_q == S_WAIT_AD && bus.block_is_ad_i) begin
            state_d = S_AD;
            cnt_val = FIRST_B;
          end else if (bus.block_last_i) begin
            state_d = S_FINAL;
          end else begin
            state_d = S_PT;
            cnt_val = FIRST_B;
          end
        end
      end
      S_AD:    if (cnt_last) state_d = ad_last_q ? S_WAIT_PT : S_WAIT_AD;
      S_PT:    if (cnt_last) state_d = S_WAIT_PT;
      S_FINAL: if (cnt_last) state_d = S_END;
      S_END: begin
        state_d  = S_IDLE;
        cnt_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_round = (state_q == S_INIT) || (state_q == S_AD) || (state_q == S_PT) || (state_q == S_FINAL);
    pt_phase = (state_q == S_PT) || (state_q == S_FINAL);
    is_first = 1'b0;
    if (state_q == S_INIT || state_q == S_FINAL) begin
      is_first = (cnt == FIRST_A);
    end else if (state_q == S_AD || state_q == S_PT) begin
      is_first = (cnt == FIRST_B);
    end
  end

  assign bus.round_o            = cnt;
  assign bus.en_reg_state_o     = in_round;
  assign bus.data_sel_o         = in_round && !is_first;
  assign bus.en_xor_data_o      = is_first && (state_q != S_INIT);
  assign bus.en_cipher_o        = is_first && pt_phase;
  assign bus.en_xor_key_begin_o = is_first && (state_q == S_FINAL);
  assign bus.en_xor_key_end_o   = cnt_last && (state_q == S_INIT || state_q == S_FINAL);
  assign bus.en_xor_lsb_o       = is_first && pt_phase && !lsb_done_q;
  assign bus.en_tag_o           = (state_q == S_END);
  assign bus.done_o             = (state_q == S_END);
  assign bus.busy_o             = (state_q != S_IDLE);
  assign bus.block_ready_o      = (state_q == S_WAIT_AD) || (state_q == S_WAIT_PT);

endmodule

// File: tb/tb_ascon_sequencer.sv
// tb/tb_ascon_sequencer.sv - randomized cycle-exact check of the sequencer against a schedule model
module tb_ascon_sequencer;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  int   total = 0;
  int   bad = 0;

  ascon_sequencer_if bus ();

  ascon_sequencer dut (
    .clock_i (clock),
    .resetb_i(resetb),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic start;
    logic valid;
    logic is_ad;
    logic last;
  } stim_t;

  stim_t       sq[$];
  logic [14:0] eq[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] outv(int rnd, bit sel, bit reg_en, bit xd, bit kb, bit ke,
                                       bit lsb, bit ci, bit tg, bit busy, bit done, bit rdy);
    return {4'(rnd), sel, reg_en, xd, kb, ke, lsb, ci, tg, busy, done, rdy};
  endfunction

  function automatic logic [14:0] dut_out();
    return {bus.round_o, bus.data_sel_o, bus.en_reg_state_o, bus.en_xor_data_o,
            bus.en_xor_key_begin_o, bus.en_xor_key_end_o, bus.en_xor_lsb_o, bus.en_cipher_o,
            bus.en_tag_o, bus.busy_o, bus.done_o, bus.block_ready_o};
  endfunction

  function automatic stim_t junk();
    stim_t t;
    t.start = 1'($urandom);
    t.valid = 1'($urandom);
    t.is_ad = 1'($urandom);
    t.last  = 1'($urandom);
    return t;
  endfunction

  // N-round permutation: round index runs 12-N..11, marks on first / last round.
  task automatic perm(int n, bit xd, bit kb, bit ke, bit ci, bit lsb);
    for (int i = 0; i < n; i++) begin
      sq.push_back(junk());
      eq.push_back(outv(12 - n + i, i != 0, 1'b1, xd && i == 0, kb && i == 0, ke && i == n - 1,
                        lsb && i == 0, ci && i == 0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic offer(bit is_ad, bit last, int stall);
    stim_t t;
    for (int s = 0; s < stall; s++) begin
      t = junk();
      t.valid = 1'b0;
      sq.push_back(t);
      eq.push_back(outv(11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    end
    t = junk();
    t.valid = 1'b1;
    t.is_ad = is_ad;
    t.last  = last;
    sq.push_back(t);
    eq.push_back(outv(11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
  endtask

  task automatic enc(int nad, int npt, int min_stall, int max_stall);
    stim_t t;
    bit    lsb_pend = 1'b1;
    bit    flag;
    bit    lastp;
    t = junk();
    t.start = 1'b1;
    sq.push_back(t);
    eq.push_back(15'd0);
    perm(12, 0, 0, 1, 0, 0);
    for (int a = 0; a < nad; a++) begin
      offer(1'b1, a == nad - 1, $urandom_range(max_stall, min_stall));
      perm(6, 1, 0, 0, 0, 0);
    end
    for (int p = 0; p < npt; p++) begin
      lastp = (p == npt - 1);
      // An AD-flagged block after the AD phase is a protocol error and still counts as PT.
      flag = (nad == 0 && p == 0) ? 1'b0 : ($urandom_range(3, 0) == 0);
      offer(flag, lastp, $urandom_range(max_stall, min_stall));
      if (lastp) perm(12, 1, 1, 1, 1, lsb_pend);
      else       perm(6, 1, 0, 0, 1, lsb_pend);
      lsb_pend = 1'b0;
    end
    sq.push_back(junk());
    eq.push_back(outv(11, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
      t = junk();
      t.start = 1'b0;
      sq.push_back(t);
      eq.push_back(15'd0);
    end
  endtask

  task automatic run(string tag);
    stim_t       t;
    logic [14:0] e;
    int          c = 0;
    while (sq.size() > 0) begin
      t = sq.pop_front();
      e = eq.pop_front();
      bus.start_i       = t.start;
      bus.block_valid_i = t.valid;
      bus.block_is_ad_i = t.is_ad;
      bus.block_last_i  = t.last;
      #0;
      check($sformatf("%s c%0d", tag, c), 32'(dut_out()), 32'(e));
      @(posedge clock);
      #1;
      c++;
    end
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.block_valid_i = 1'b0;
    bus.block_is_ad_i = 1'b0;
    bus.block_last_i  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset", 32'(dut_out()), 32'd0);
    resetb = 1'b1;
    @(posedge clock);
    #1;

    enc(0, 1, 0, 0);
    run("no_ad");
    enc(2, 2, 0, 0);
    run("ad2_pt2");
    enc(1, 2, 5, 5);
    run("stall5");

    bus.start_i = 1'b1;
    @(posedge clock);
    #1;
    bus.start_i = 1'b0;
    bus.block_valid_i = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("rst_round", 32'(bus.round_o), 32'd5);
    #2;
    resetb = 1'b0;
    #1;
    check("rst_async", 32'(dut_out()), 32'd0);
    bus.start_i = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("rst_hold", 32'(dut_out()), 32'd0);
    end
    bus.start_i = 1'b0;
    #2;
    resetb = 1'b1;
    @(posedge clock);
    #1;
    check("rst_idle", 32'(dut_out()), 32'd0);
    enc(1, 1, 0, 2);
    run("after_rst");

    for (int k = 0; k < 25; k++) begin
      enc($urandom_range(3, 0), $urandom_range(3, 1), 0, 5);
      run($sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
